// File: rtl/fsm_run_detect.sv
// fsm_run_detect: detects a run of `thr` consecutive samples of T equal to
// `match`, with level or non-overlapping pulse output, a saturating run-length
// counter and a saturating detection counter. All outputs are registered.
module fsm_run_detect #(
  parameter int CNT_W = 4,
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             T,
  input  logic             match,
  input  logic             mode,
  input  logic [CNT_W-1:0] thr,
  input  logic             clr_hits,
  output logic             out,
  output logic [CNT_W-1:0] run_cnt,
  output logic [HIT_W-1:0] hit_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] run_nx, teff, run_inc;
  logic             out_nx, hit_entry, smatch, restart;

  assign state_o = state;

  // Next-state decode; pulse-mode HIT samples exactly like IDLE so the run restarts from zero
  always_comb begin
    teff      = (thr == '0) ? CNT_W'(1) : thr;
    run_inc   = (run_cnt == '1) ? run_cnt : run_cnt + CNT_W'(1);
    smatch    = (T == match);
    restart   = (state == IDLE) || ((state == HIT) && mode);
    state_nx  = state;
    run_nx    = run_cnt;
    out_nx    = out && !mode;
    hit_entry = 1'b0;
    case (state)
      IDLE, RUN, HIT: begin
        if (en) begin
          if (!smatch) begin
            state_nx = IDLE;
            run_nx   = '0;
          end else if (restart) begin
            run_nx   = CNT_W'(1);
            state_nx = (teff == CNT_W'(1)) ? HIT : RUN;
          end else if (state == RUN) begin
            run_nx   = run_inc;
            state_nx = ((CNT_W+1)'(run_cnt) + (CNT_W+1)'(1) >= (CNT_W+1)'(teff)) ? HIT : RUN;
          end else begin
            run_nx   = run_inc;
          end
          hit_entry = (state_nx == HIT) && (restart || (state == RUN));
          out_nx    = mode ? hit_entry : (state_nx == HIT);
        end
      end
      default: begin
        state_nx = IDLE;
        run_nx   = '0;
        out_nx   = 1'b0;
      end
    endcase
  end

  // State, output and counter registers; rst overrides everything, clr_hits beats a same-edge hit
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      run_cnt <= '0;
      out     <= 1'b0;
      hit_cnt <= '0;
    end else begin
      state   <= state_nx;
      run_cnt <= run_nx;
      out     <= out_nx;
      if (clr_hits)
        hit_cnt <= '0;
      else if (hit_entry && (hit_cnt != '1))
        hit_cnt <= hit_cnt + HIT_W'(1);
    end
  end

endmodule
